// File: rtl/sipo_if.sv
// Bundle of the UART receive line, frame configuration and host-side results.
// The line/config side drives the master modport; the receiver takes the slave.
interface sipo_if;
    logic       rx;
    logic       data_length;
    logic       stop_bits;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       rx_active;
    logic       rx_done;
    logic       parity_error;
    logic       framing_error;

    modport master (
        output rx, data_length, stop_bits, parity_type,
        input  data_out, rx_active, rx_done, parity_error, framing_error
    );

    modport slave (
        input  rx, data_length, stop_bits, parity_type,
        output data_out, rx_active, rx_done, parity_error, framing_error
    );
endinterface

// File: rtl/sipo.sv
// UART receiver: oversampled, mid-bit sampled serial-in/parallel-out with 7/8 data bits,
// optional odd/even parity, one or two stop bits and break detection.
module sipo #(
    parameter int OVERSAMPLE = 16
) (
    input  logic    baud_clk,
    input  logic    rst,
    sipo_if.slave   bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BREAK
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      rx_sync_reg;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic            cfg_len_reg, cfg_len_next;
    logic            cfg_stop2_reg, cfg_stop2_next;
    logic [1:0]      cfg_par_reg, cfg_par_next;
    logic            pend_pe_reg, pend_pe_next;
    logic            pend_fe_reg, pend_fe_next;
    logic [7:0]      data_out_reg, data_out_next;
    logic            rx_active_reg, rx_active_next;
    logic            rx_done_reg, rx_done_next;
    logic            pe_reg, pe_next;
    logic            fe_reg, fe_next;

    logic            rx_s;
    logic            mid;
    logic            bit_end;
    logic            capture;
    logic            clear_shift;
    logic            finish;
    logic            fe_now;
    logic            par_en;
    logic            data_par;
    logic [2:0]      last_idx;
    logic [7:0]      data_masked;

    assign rx_s        = rx_sync_reg[1];
    assign mid         = (cnt_reg == MID_CNT);
    assign bit_end     = (cnt_reg == LAST_CNT);
    assign par_en      = (cfg_par_reg == 2'b01) || (cfg_par_reg == 2'b10);
    assign last_idx    = cfg_len_reg ? 3'd7 : 3'd6;
    assign data_masked = {cfg_len_reg & shift_reg[7], shift_reg[6:0]};
    assign data_par    = ^data_masked;

    // Each data bit lands in its own slot; the register is zeroed on every start edge.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = clear_shift ? 1'b0 :
                                    (capture && (bit_idx_reg == 3'(gi))) ? rx_s :
                                    shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        bit_idx_next   = bit_idx_reg;
        cfg_len_next   = cfg_len_reg;
        cfg_stop2_next = cfg_stop2_reg;
        cfg_par_next   = cfg_par_reg;
        pend_pe_next   = pend_pe_reg;
        pend_fe_next   = pend_fe_reg;
        data_out_next  = data_out_reg;
        rx_active_next = rx_active_reg;
        rx_done_next   = 1'b0;
        pe_next        = pe_reg;
        fe_next        = fe_reg;
        capture        = 1'b0;
        clear_shift    = 1'b0;
        finish         = 1'b0;
        fe_now         = 1'b0;

        if (state_reg == IDLE || state_reg == BREAK) begin
            cnt_next = '0;
        end else begin
            cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next     = START;
                    cnt_next       = '0;
                    cfg_len_next   = bus.data_length;
                    cfg_stop2_next = bus.stop_bits;
                    cfg_par_next   = bus.parity_type;
                    pend_pe_next   = 1'b0;
                    pend_fe_next   = 1'b0;
                    clear_shift    = 1'b1;
                end
            end
            START: begin
                if (mid) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        rx_active_next = 1'b1;
                    end
                end else if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (mid) begin
                    capture = 1'b1;
                end
                if (bit_end) begin
                    if (bit_idx_reg == last_idx) begin
                        state_next = par_en ? PARITY : STOP1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                // Even parity wants an even total including the parity bit, odd wants odd.
                if (mid) begin
                    if (cfg_par_reg == 2'b10) begin
                        if (data_par ^ rx_s) pend_pe_next = 1'b1;
                    end else begin
                        if (!(data_par ^ rx_s)) pend_pe_next = 1'b1;
                    end
                end
                if (bit_end) begin
                    state_next = STOP1;
                end
            end
            STOP1: begin
                if (mid) begin
                    if (cfg_stop2_reg) begin
                        if (!rx_s) pend_fe_next = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end else if (bit_end) begin
                    state_next = STOP2;
                end
            end
            STOP2: begin
                if (mid) begin
                    finish = 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Frame completes at the last stop bit's mid-sample, leaving half a bit of slack
        // before the next start edge.
        if (finish) begin
            fe_now         = pend_fe_reg | ~rx_s;
            data_out_next  = data_masked;
            pe_next        = pend_pe_reg;
            fe_next        = fe_now;
            rx_done_next   = 1'b1;
            rx_active_next = 1'b0;
            state_next     = (fe_now && (data_masked == 8'h00) && !rx_s) ? BREAK : IDLE;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rx_sync_reg   <= 2'b11;
            cnt_reg       <= '0;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            cfg_len_reg   <= 1'b0;
            cfg_stop2_reg <= 1'b0;
            cfg_par_reg   <= 2'b00;
            pend_pe_reg   <= 1'b0;
            pend_fe_reg   <= 1'b0;
            data_out_reg  <= 8'h00;
            rx_active_reg <= 1'b0;
            rx_done_reg   <= 1'b0;
            pe_reg        <= 1'b0;
            fe_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rx_sync_reg   <= {rx_sync_reg[0], bus.rx};
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            cfg_len_reg   <= cfg_len_next;
            cfg_stop2_reg <= cfg_stop2_next;
            cfg_par_reg   <= cfg_par_next;
            pend_pe_reg   <= pend_pe_next;
            pend_fe_reg   <= pend_fe_next;
            data_out_reg  <= data_out_next;
            rx_active_reg <= rx_active_next;
            rx_done_reg   <= rx_done_next;
            pe_reg        <= pe_next;
            fe_reg        <= fe_next;
        end
    end

    assign bus.data_out      = data_out_reg;
    assign bus.rx_active     = rx_active_reg;
    assign bus.rx_done       = rx_done_reg;
    assign bus.parity_error  = pe_reg;
    assign bus.framing_error = fe_reg;
endmodule

// File: tb/tb_sipo.sv
// Bench for the UART receiver: table of frames driven serially, results checked from a
// scoreboard on every rx_done, plus glitch, break and mid-frame reset sequences.
module tb_sipo;
    localparam int OS = 16;

    logic baud_clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_strobes = 0;
    int   n_pushed = 0;

    sipo_if bus ();

    sipo #(.OVERSAMPLE(OS)) dut (
        .baud_clk (baud_clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial begin
        baud_clk = 1'b0;
        forever #5 baud_clk = ~baud_clk;
    end

    always @(posedge baud_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       len8;
        logic [1:0] ptype;
        logic       stop2;
        logic       par;
        logic       s1;
        logic       s2;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every rx_done must match the oldest outstanding expectation.
    always @(negedge baud_clk) begin
        if (bus.rx_done) begin
            exp_t e;
            n_strobes++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rx_done: got strobe data 0x%0h, expected none (cycle %0d)",
                         bus.data_out, cyc);
            end else begin
                e = sb.pop_front();
                $display("rx_done cycle %0d data 0x%02h pe %0b fe %0b", cyc, bus.data_out,
                         bus.parity_error, bus.framing_error);
                check("data_out", int'(bus.data_out), int'(e.d));
                check("parity_error", int'(bus.parity_error), int'(e.pe));
                check("framing_error", int'(bus.framing_error), int'(e.fe));
                check("rx_active_at_done", int'(bus.rx_active), 0);
                if (e.cyc >= 0) begin
                    n_cmp++;
                    if (cyc < e.cyc - 2 || cyc > e.cyc + 2) begin
                        n_bad++;
                        $display("FAIL latency: got cycle %0d, expected %0d +/-2", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (OS) @(negedge baud_clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input int c);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        e.cyc = c;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic send_frame(input vec_t v);
        int nb;
        int par_en;
        int total;
        nb     = v.len8 ? 8 : 7;
        par_en = (v.ptype == 2'b01 || v.ptype == 2'b10) ? 1 : 0;
        total  = 1 + nb + par_en + 1 + (v.stop2 ? 1 : 0);
        bus.data_length = v.len8;
        bus.parity_type = v.ptype;
        bus.stop_bits   = v.stop2;
        push_exp(v.exp_data, v.exp_pe, v.exp_fe, cyc + OS * (total - 1) + 11);
        send_bit(1'b0);
        // Scramble the configuration during the frame; the receiver must have latched it.
        bus.data_length = ~v.len8;
        bus.parity_type = ~v.ptype;
        bus.stop_bits   = ~v.stop2;
        for (int i = 0; i < nb; i++) send_bit(v.data[i]);
        bus.data_length = v.len8;
        bus.parity_type = v.ptype;
        bus.stop_bits   = v.stop2;
        if (par_en != 0) send_bit(v.par);
        send_bit(v.s1);
        if (v.stop2) send_bit(v.s2);
        for (int i = 0; i < v.gap; i++) send_bit(1'b1);
    endtask

    initial begin
        vec_t v;
        int   seen_active;
        int   w;

        //          data   len8  ptype  stop2 par   s1    s2   gap  exp    pe    fe
        vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h75, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h75, 1'b0, 1'b0};
        vecs[2] = '{8'h75, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h75, 1'b1, 1'b0};
        vecs[3] = '{8'h35, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h35, 1'b0, 1'b0};
        vecs[4] = '{8'hB5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h35, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h81, 1'b1, 1'b0};
        vecs[8] = '{8'h5A, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2, 8'h5A, 1'b0, 1'b1};
        vecs[9] = '{8'h3C, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2, 8'h3C, 1'b1, 1'b1};

        rst = 1'b1;
        bus.rx = 1'b1;
        bus.data_length = 1'b1;
        bus.stop_bits = 1'b0;
        bus.parity_type = 2'b00;
        repeat (3) @(negedge baud_clk);
        check("reset_data_out", int'(bus.data_out), 0);
        check("reset_rx_active", int'(bus.rx_active), 0);
        check("reset_rx_done", int'(bus.rx_done), 0);
        check("reset_parity_error", int'(bus.parity_error), 0);
        check("reset_framing_error", int'(bus.framing_error), 0);
        rst = 1'b0;
        repeat (2) send_bit(1'b1);

        // Short low glitch must be rejected at the start-bit mid-sample.
        bus.rx = 1'b0;
        repeat (6) @(negedge baud_clk);
        bus.rx = 1'b1;
        seen_active = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge baud_clk);
            if (bus.rx_active) seen_active = 1;
        end
        check("glitch_rx_active", seen_active, 0);
        $display("glitch 6 cycles: rx_active seen %0d", seen_active);

        for (int i = 0; i < 10; i++) begin
            $display("frame %0d: data 0x%02h len8 %0b ptype %02b stop2 %0b", i, vecs[i].data,
                     vecs[i].len8, vecs[i].ptype, vecs[i].stop2);
            send_frame(vecs[i]);
        end

        // Break: bad stop bit on 0x3C, line then stays low; expect one all-zero break frame.
        v = '{8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 1'b1};
        send_frame(v);
        push_exp(8'h00, 1'b0, 1'b1, -1);
        repeat (30) send_bit(1'b0);
        repeat (2) send_bit(1'b1);
        v = '{8'h81, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'h81, 1'b0, 1'b0};
        send_frame(v);
        $display("break sequence done, strobes so far %0d", n_strobes);

        // Reset during data bit 4 of 0x5A discards the frame.
        bus.data_length = 1'b1;
        bus.parity_type = 2'b00;
        bus.stop_bits = 1'b0;
        v = '{8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'h5A, 1'b0, 1'b0};
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v.data[i]);
        bus.rx = v.data[4];
        repeat (OS / 2) @(negedge baud_clk);
        check("midframe_rx_active", int'(bus.rx_active), 1);
        rst = 1'b1;
        bus.rx = 1'b1;
        @(negedge baud_clk);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_rx_active", int'(bus.rx_active), 0);
        check("rst_rx_done", int'(bus.rx_done), 0);
        check("rst_parity_error", int'(bus.parity_error), 0);
        check("rst_framing_error", int'(bus.framing_error), 0);
        rst = 1'b0;
        $display("mid-frame reset applied at cycle %0d", cyc);
        repeat (2) send_bit(1'b1);
        send_frame(v);

        w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(negedge baud_clk);
            w++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (4 * OS) @(negedge baud_clk);
        check("strobe_count", n_strobes, n_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
